// File: rtl/stream_accum_if.sv
// Valid/ready stream bundle shared by the sample input and the group-sum output
// of stream_accum. The master drives valid/data, the slave drives ready.
interface stream_accum_if #(
  parameter int DW = 64
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_accum.sv
// stream_accum: sums ACC_NUM consecutive unsigned samples into an OUT_DW-bit
// accumulator and presents the group sum on a valid/ready master port. The sum
// is held until accepted; input is stalled meanwhile. Any carry out of the top
// accumulator bit sets a sticky overflow flag; the wrapped sum is still output.
module stream_accum #(
  parameter int IN_DW   = 64,
  parameter int OUT_DW  = 72,
  parameter int ACC_NUM = 100
) (
  input  logic           clk,
  input  logic           rstn,
  stream_accum_if.slave  s,
  stream_accum_if.master m,
  output logic           o_ovf
);

  localparam int CNT_W = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;
  // Zero-extension width that brings a sample up to OUT_DW+1 bits (carry bit included).
  localparam int EXT_W = OUT_DW + 1 - IN_DW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_NUM - 1);

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                ready_r;
  logic [OUT_DW-1:0]   acc_r;
  logic [OUT_DW-1:0]   data_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ovf_r;

  logic                i_hs_s;
  logic                o_hs_s;
  logic                last_s;
  logic [OUT_DW:0]     sum_s;
  logic                acc_en_s;
  logic                close_s;

  // s_ready is a register, so m_ready never reaches it combinationally.
  assign s.ready = ready_r;
  assign m.valid = (state_r == S_OUT);
  assign m.data  = data_r;
  assign o_ovf   = ovf_r;

  assign i_hs_s = s.valid & ready_r;
  assign o_hs_s = (state_r == S_OUT) & m.ready;
  assign last_s = (cnt_r == CNT_LAST);
  // One extra bit on top captures the carry out of the accumulator.
  assign sum_s  = {1'b0, acc_r} + {{EXT_W{1'b0}}, s.data};

  // State register and registered input-ready, which follows the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_ACC;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == S_ACC);
    end
  end

  // Next-state decode: close a group on its last sample, release on output handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_ACC: begin
        if (i_hs_s && last_s) begin
          state_nxt_s = S_OUT;
        end else begin
          state_nxt_s = S_ACC;
        end
      end
      S_OUT: begin
        if (o_hs_s) begin
          state_nxt_s = S_ACC;
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      default: state_nxt_s = S_ACC;
    endcase
  end

  // Datapath controls: accumulate a mid-group sample or close the group.
  always_comb begin
    acc_en_s = 1'b0;
    close_s  = 1'b0;
    case (state_r)
      S_ACC: begin
        if (i_hs_s) begin
          if (last_s) begin
            close_s = 1'b1;
          end else begin
            acc_en_s = 1'b1;
          end
        end else begin
          acc_en_s = 1'b0;
          close_s  = 1'b0;
        end
      end
      S_OUT: begin
        acc_en_s = 1'b0;
        close_s  = 1'b0;
      end
      default: begin
        acc_en_s = 1'b0;
        close_s  = 1'b0;
      end
    endcase
  end

  // Accumulator, sample counter and held output sum (not cleared after handoff).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r  <= {OUT_DW{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      data_r <= {OUT_DW{1'b0}};
    end else if (acc_en_s) begin
      acc_r <= sum_s[OUT_DW-1:0];
      cnt_r <= cnt_r + CNT_W'(1);
    end else if (close_s) begin
      data_r <= sum_s[OUT_DW-1:0];
      acc_r  <= {OUT_DW{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end
  end

  // Sticky overflow: any carry out of the accumulator on an accepted add.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_r <= 1'b0;
    end else if ((acc_en_s || close_s) && sum_s[OUT_DW]) begin
      ovf_r <= 1'b1;
    end
  end

endmodule
